hcsr04_distance_meter: RTL and testbench
========================================

# hcsr04_distance_meter

Upstream stage of the distance display path. It drives an HC-SR04 ultrasonic ranger: it fires a trigger pulse, times the echo pulse, and converts the echo width to whole centimetres without a divider. It presents the result as a 9-bit `distance` word, which the ASCII formatter downstream splits into hundreds, tens and units. Each measurement is started by a request pulse. A mandatory hold-off between shots protects the sensor.

## Interface
Parameters:
- `CLKS_PER_US`, 100: system clocks per microsecond (100 MHz).
- `TRIG_US`, 10: trigger pulse width in µs.
- `US_PER_CM`, 58: echo µs per centimetre of range.
- `MAX_CM`, 400: saturation value of `distance`.
- `ECHO_WAIT_US`, 30000: maximum µs from trigger fall to echo rise.
- `ECHO_MAX_US`, 30000: maximum echo-high µs before abort.
- `HOLDOFF_US`, 60000: minimum µs from end of a cycle to the next trigger.

Ports:
- `clk`, in, 1: system clock. The block uses one clock only.
- `rst`, in, 1: reset, synchronous and active-high.
- `start`, in, 1: one-cycle measurement request. It is honoured only in IDLE and ignored otherwise.
- `echo`, in, 1: sensor echo, asynchronous.
- `trig`, out, 1: sensor trigger.
- `distance`, out, 9: last good range in cm, 0..`MAX_CM`.
- `dist_valid`, out, 1: one-cycle strobe when `distance` is updated.
- `timeout`, out, 1: one-cycle strobe when a measurement aborts.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- `echo` passes through a 2-FF synchronizer. A rise or fall is detected from the synchronized value and its one-cycle-delayed copy.
- A µs tick generator counts 0..`CLKS_PER_US`-1 and emits a 1-cycle `tick_us` at terminal count. It restarts from 0 on every state entry, so all durations are exact multiples of `CLKS_PER_US` cycles.
- State machine:
  - **IDLE**
    - `trig`=0.
    - `start` → TRIG.
  - **TRIG**
    - `trig`=1 for exactly `TRIG_US`×`CLKS_PER_US` cycles.
    - Then → WAIT_ECHO.
  - **WAIT_ECHO**
    - A synchronized echo rise → MEASURE, with `us_sub`=0 and `cm_cnt`=0.
    - `ECHO_WAIT_US` ticks with no rise → pulse `timeout` and go → HOLDOFF.
  - **MEASURE**
    - On each `tick_us` while echo is high, increment `us_sub`. At `US_PER_CM`-1 it wraps to 0 and `cm_cnt` increments; `cm_cnt` saturates at `MAX_CM`.
    - Echo fall → `distance` ← `cm_cnt` (truncated; partial cm is dropped), pulse `dist_valid`, go → HOLDOFF.
    - `ECHO_MAX_US` ticks with echo still high → pulse `timeout`, go → HOLDOFF, and `distance` is unchanged.
  - **HOLDOFF**
    - Wait `HOLDOFF_US` ticks, then → IDLE.
    - `start` is ignored here.
- Width rules:
  - `cm_cnt` is 9 bits.
  - `us_sub` is `$clog2(US_PER_CM)` bits.
  - The duration counter is wide enough for the largest of the µs parameters (17 bits at the defaults).
- If echo is already high when WAIT_ECHO is entered, the block waits for a genuine rise. A level that is high on entry is not a rise.
- If echo falls and a timeout expires in the same cycle in MEASURE, the fall wins: the result is a valid distance and no `timeout` pulse is issued.

## Timing
- Reset values: `trig`=0, `distance`=0, `dist_valid`=0, `timeout`=0, `busy`=0, state=IDLE, all counters 0.
- A `rst` asserted mid-cycle drops `trig` on the next edge, and the block returns to IDLE without issuing any strobe.
- `start` sampled high in IDLE at edge N gives `trig`=1 and `busy`=1 from edge N+1.
- Echo path latency is 2 synchronizer cycles plus 1 edge-detect cycle. `dist_valid` and the new `distance` appear 3 cycles after the raw echo fall and are coincident.
- `distance` holds its value between updates. The downstream formatter may sample it at any time.
- `dist_valid` and `timeout` are never high together, and each lasts exactly 1 cycle.
- Full cycle period is at least `TRIG_US` + `HOLDOFF_US` µs, which guarantees the sensor's recovery time.

## Structure
- Shared package `hcsr04_pkg`:
  - state enum: IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF;
  - `DIST_W`=9;
  - default timing constants.
- Sub-module `us_tick_gen`:
  - inputs: `clk`, `rst`, `clr`;
  - output: `tick_us`;
  - parameter: `CLKS_PER_US`.
  - It is reused by other sensor blocks.
- The synchronizer and edge detect are inline. Target size is ~200 lines.

## Test plan
Benches use `CLKS_PER_US`=10 and `HOLDOFF_US`=100 to shorten runs.
- Reset with `start` held high → all outputs 0, state stays IDLE until the first post-reset `start`.
- `start` pulse → `trig` high for exactly 100 cycles, then low; `busy` is high throughout.
- Echo high for 58×20 µs (11600 cycles) → `distance`=20, `dist_valid` a single pulse 3 cycles after the fall. Echo of 57 µs → `distance`=0 with a valid strobe.
- Echo high for 29000 µs (500 cm) → `distance`=400 (saturated) on the fall, no `timeout`.
- No echo after trigger → `timeout` pulse at exactly `ECHO_WAIT_US` ticks after trigger fall; `distance` keeps its previous value of 20. Echo held high past `ECHO_MAX_US` → `timeout`, `distance` unchanged.
- `start` during HOLDOFF is ignored; the next `start` after `busy` falls triggers. `rst` asserted in MEASURE → `trig`=0, no strobes, IDLE the next cycle.

Source files
------------

// File: rtl/hcsr04_pkg.sv
// Shared types and default timing for the HC-SR04 ranging blocks.
package hcsr04_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_ECHO = 3'd2,
    MEASURE   = 3'd3,
    HOLDOFF   = 3'd4
  } state_t;

  localparam int DIST_W = 9;

  localparam int DEF_CLKS_PER_US  = 100;
  localparam int DEF_TRIG_US      = 10;
  localparam int DEF_US_PER_CM    = 58;
  localparam int DEF_MAX_CM       = 400;
  localparam int DEF_ECHO_WAIT_US = 30000;
  localparam int DEF_ECHO_MAX_US  = 30000;
  localparam int DEF_HOLDOFF_US   = 60000;

  // Largest of four durations, used to size the shared duration counter.
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/hcsr04_distance_meter_us_tick_gen.sv
// Microsecond tick generator: one-cycle pulse every CLKS_PER_US clocks,
// restartable so that a new phase always begins with a full microsecond.
module us_tick_gen #(
  parameter int CLKS_PER_US = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick_us
);

  localparam int CW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_US - 1);

  logic [CW-1:0] cnt_r;

  // Free-running prescaler, cleared on reset or on request.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (cnt_r == LAST) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign tick_us = (cnt_r == LAST);

endmodule

// File: rtl/hcsr04_distance_meter.sv
// HC-SR04 driver: fires the trigger, times the echo and converts its width
// to whole centimetres by counting microseconds in groups of US_PER_CM.
module hcsr04_distance_meter
  import hcsr04_pkg::*;
#(
  parameter int CLKS_PER_US  = DEF_CLKS_PER_US,
  parameter int TRIG_US      = DEF_TRIG_US,
  parameter int US_PER_CM    = DEF_US_PER_CM,
  parameter int MAX_CM       = DEF_MAX_CM,
  parameter int ECHO_WAIT_US = DEF_ECHO_WAIT_US,
  parameter int ECHO_MAX_US  = DEF_ECHO_MAX_US,
  parameter int HOLDOFF_US   = DEF_HOLDOFF_US
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              echo,
  output logic              trig,
  output logic [DIST_W-1:0] distance,
  output logic              dist_valid,
  output logic              timeout,
  output logic              busy
);

  localparam int DUR_MAX = max4(TRIG_US, ECHO_WAIT_US, ECHO_MAX_US, HOLDOFF_US);
  localparam int DUR_W   = $clog2(DUR_MAX) + 1;
  localparam int US_W    = $clog2(US_PER_CM);

  localparam logic [DUR_W-1:0]  TRIG_LAST = DUR_W'(TRIG_US - 1);
  localparam logic [DUR_W-1:0]  WAIT_LAST = DUR_W'(ECHO_WAIT_US - 1);
  localparam logic [DUR_W-1:0]  EMAX_LAST = DUR_W'(ECHO_MAX_US - 1);
  localparam logic [DUR_W-1:0]  HOLD_LAST = DUR_W'(HOLDOFF_US - 1);
  localparam logic [US_W-1:0]   US_LAST   = US_W'(US_PER_CM - 1);
  localparam logic [DIST_W-1:0] CM_MAX    = DIST_W'(MAX_CM);

  state_t state_r, state_next_s;
  logic   state_entry_s;
  logic   tick_us_s;

  logic echo_s1_r, echo_s2_r, echo_d_r;
  logic echo_rise_s, echo_fall_s;

  logic [DUR_W-1:0]  dur_r;
  logic [US_W-1:0]   us_sub_r, us_next_s;
  logic [DIST_W-1:0] cm_cnt_r, cm_next_s;
  logic              dv_next_s, to_next_s;

  logic              trig_r, busy_r, dv_r, to_r;
  logic [DIST_W-1:0] distance_r;

  // The prescaler restarts whenever the state changes so every phase
  // lasts an exact number of microseconds.
  assign state_entry_s = (state_next_s != state_r);

  us_tick_gen #(.CLKS_PER_US(CLKS_PER_US)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_entry_s),
    .tick_us (tick_us_s)
  );

  // Two-flop synchronizer for the asynchronous echo plus a delayed copy for edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      echo_s1_r <= 1'b0;
      echo_s2_r <= 1'b0;
      echo_d_r  <= 1'b0;
    end else begin
      echo_s1_r <= echo;
      echo_s2_r <= echo_s1_r;
      echo_d_r  <= echo_s2_r;
    end
  end

  assign echo_rise_s = echo_s2_r & ~echo_d_r;
  assign echo_fall_s = ~echo_s2_r & echo_d_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and strobe decode; an echo fall takes priority over an
  // expiring measurement window.
  always_comb begin
    state_next_s = state_r;
    dv_next_s    = 1'b0;
    to_next_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = TRIG;
        else       state_next_s = IDLE;
      end
      TRIG: begin
        if (tick_us_s && (dur_r == TRIG_LAST)) state_next_s = WAIT_ECHO;
        else                                   state_next_s = TRIG;
      end
      WAIT_ECHO: begin
        if (echo_rise_s) begin
          state_next_s = MEASURE;
        end else if (tick_us_s && (dur_r == WAIT_LAST)) begin
          to_next_s    = 1'b1;
          state_next_s = HOLDOFF;
        end else begin
          state_next_s = WAIT_ECHO;
        end
      end
      MEASURE: begin
        if (echo_fall_s) begin
          dv_next_s    = 1'b1;
          state_next_s = HOLDOFF;
        end else if (tick_us_s && (dur_r == EMAX_LAST)) begin
          to_next_s    = 1'b1;
          state_next_s = HOLDOFF;
        end else begin
          state_next_s = MEASURE;
        end
      end
      HOLDOFF: begin
        if (tick_us_s && (dur_r == HOLD_LAST)) state_next_s = IDLE;
        else                                   state_next_s = HOLDOFF;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Centimetre accumulator step. MEASURE is only occupied while echo is high,
  // so every tick there counts, including the one in the fall cycle.
  always_comb begin
    us_next_s = us_sub_r;
    cm_next_s = cm_cnt_r;
    if (!tick_us_s) begin
      us_next_s = us_sub_r;
    end else if (us_sub_r == US_LAST) begin
      us_next_s = {US_W{1'b0}};
      if (cm_cnt_r < CM_MAX) cm_next_s = cm_cnt_r + {{(DIST_W-1){1'b0}}, 1'b1};
      else                   cm_next_s = cm_cnt_r;
    end else begin
      us_next_s = us_sub_r + {{(US_W-1){1'b0}}, 1'b1};
    end
  end

  // Duration and range counters, all restarted on state entry.
  always_ff @(posedge clk) begin
    if (rst || state_entry_s) begin
      dur_r    <= {DUR_W{1'b0}};
      us_sub_r <= {US_W{1'b0}};
      cm_cnt_r <= {DIST_W{1'b0}};
    end else begin
      if (tick_us_s && (state_r != IDLE)) dur_r <= dur_r + {{(DUR_W-1){1'b0}}, 1'b1};
      if (state_r == MEASURE) begin
        us_sub_r <= us_next_s;
        cm_cnt_r <= cm_next_s;
      end
    end
  end

  // Registered outputs; the result is latched together with its strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_r     <= 1'b0;
      busy_r     <= 1'b0;
      dv_r       <= 1'b0;
      to_r       <= 1'b0;
      distance_r <= {DIST_W{1'b0}};
    end else begin
      trig_r <= (state_next_s == TRIG);
      busy_r <= (state_next_s != IDLE);
      dv_r   <= dv_next_s;
      to_r   <= to_next_s;
      if (dv_next_s) distance_r <= cm_next_s;
    end
  end

  assign trig       = trig_r;
  assign busy       = busy_r;
  assign dist_valid = dv_r;
  assign timeout    = to_r;
  assign distance   = distance_r;

endmodule

// File: tb/tb_hcsr04_distance_meter.sv
// Self-checking bench for hcsr04_distance_meter with shortened timing.
module tb_hcsr04_distance_meter;

  localparam int CLKS      = 10;
  localparam int TRIG_US   = 10;
  localparam int US_PER_CM = 58;
  localparam int MAX_CM    = 20;
  localparam int WAIT_US   = 200;
  localparam int EMAX_US   = 1300;
  localparam int HOLD_US   = 100;

  logic       clk = 1'b0;
  logic       rst, start, echo;
  logic       trig, dist_valid, timeout, busy;
  logic [8:0] distance;

  int n_tests = 0;
  int n_fail  = 0;
  int dv_cnt = 0, to_cnt = 0, both_cnt = 0, long_cnt = 0;
  logic dv_q = 1'b0, to_q = 1'b0;

  typedef struct {
    string name;
    int    pre_us;
    int    delay_us;
    int    width_us;
    logic  exp_valid;
    int    exp_t;
    int    exp_dist;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  hcsr04_distance_meter #(
    .CLKS_PER_US(CLKS), .TRIG_US(TRIG_US), .US_PER_CM(US_PER_CM), .MAX_CM(MAX_CM),
    .ECHO_WAIT_US(WAIT_US), .ECHO_MAX_US(EMAX_US), .HOLDOFF_US(HOLD_US)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .echo(echo), .trig(trig),
    .distance(distance), .dist_valid(dist_valid), .timeout(timeout), .busy(busy)
  );

  // Strobe monitor: counts pulses, overlaps and pulses longer than one cycle.
  always @(negedge clk) begin
    if (dist_valid === 1'b1) dv_cnt <= dv_cnt + 1;
    if (timeout === 1'b1) to_cnt <= to_cnt + 1;
    if (dist_valid === 1'b1 && timeout === 1'b1) both_cnt <= both_cnt + 1;
    if ((dist_valid === 1'b1 && dv_q) || (timeout === 1'b1 && to_q)) long_cnt <= long_cnt + 1;
    dv_q <= (dist_valid === 1'b1);
    to_q <= (timeout === 1'b1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: outcome of one shot from the echo timing alone.
  // Times are cycles counted from the sample where trig is first seen low.
  function automatic void model(input int delay_us, input int width_us, input int prev,
                                output logic v, output int t, output int d);
    if (width_us == 0) begin
      v = 1'b0; t = WAIT_US * CLKS; d = prev;
    end else if (width_us > EMAX_US) begin
      v = 1'b0; t = delay_us * CLKS + 3 + EMAX_US * CLKS; d = prev;
    end else begin
      v = 1'b1; t = (delay_us + width_us) * CLKS + 3;
      d = width_us / US_PER_CM;
      if (d > MAX_CM) d = MAX_CM;
    end
  endfunction

  task automatic run(input string name, input int pre_us, input int delay_us, input int width_us,
                     input logic exp_valid, input int exp_t, input int exp_dist);
    int   trig_len, ev_t, w, dv0, to0;
    logic busy_ok, ev_dv, ev_to;
    dv0 = dv_cnt; to0 = to_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    check($sformatf("%s.trig_rise", name), trig, 1);
    check($sformatf("%s.busy_rise", name), busy, 1);
    if (pre_us > 0) echo = 1'b1;
    trig_len = 1; busy_ok = 1'b1;
    while (trig === 1'b1 && trig_len < 10000) begin
      tick();
      if (trig === 1'b1) trig_len++;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    check($sformatf("%s.trig_len", name), trig_len, TRIG_US * CLKS);
    check($sformatf("%s.busy_in_trig", name), busy_ok, 1);
    ev_dv = 1'b0; ev_to = 1'b0; ev_t = -1;
    for (int t = 0; t < 40000; t++) begin
      if (dist_valid === 1'b1 || timeout === 1'b1) begin
        ev_dv = dist_valid; ev_to = timeout; ev_t = t;
        break;
      end
      echo = (t < pre_us * CLKS) ||
             (width_us > 0 && t >= delay_us * CLKS && t < (delay_us + width_us) * CLKS);
      tick();
    end
    echo = 1'b0;
    check($sformatf("%s.valid", name), ev_dv, exp_valid);
    check($sformatf("%s.timeout", name), ev_to, !exp_valid);
    check($sformatf("%s.event_time", name), ev_t, exp_t);
    check($sformatf("%s.distance", name), distance, exp_dist);
    w = 0;
    while (busy === 1'b1 && w < 5000) begin
      start = (w == 5);
      tick();
      w++;
    end
    start = 1'b0;
    check($sformatf("%s.holdoff_len", name), w, HOLD_US * CLKS);
    check($sformatf("%s.dist_hold", name), distance, exp_dist);
    repeat (20) tick();
    check($sformatf("%s.holdoff_start_ignored", name), busy, 0);
    check($sformatf("%s.dv_pulses", name), dv_cnt - dv0, exp_valid ? 1 : 0);
    check($sformatf("%s.to_pulses", name), to_cnt - to0, exp_valid ? 0 : 1);
  endtask

  initial begin
    int   prev, d_us, w_us, et, ed, n;
    logic ev;

    vecs[0] = '{"cm20",        0, 10, 1160, 1'b1, 11703, 20};
    vecs[1] = '{"no_echo",     0,  0,    0, 1'b0,  2000, 20};
    vecs[2] = '{"us57",        0,  5,   57, 1'b1,   623,  0};
    vecs[3] = '{"echo_max",    0,  4, 1350, 1'b0, 13043,  0};
    vecs[4] = '{"sat_fallwin", 0,  4, 1300, 1'b1, 13043, 20};
    vecs[5] = '{"pre_high",    5, 20,  174, 1'b1,  1943,  3};

    rst = 1'b1; start = 1'b1; echo = 1'b0;
    repeat (5) tick();
    check("rst.trig", trig, 0);
    check("rst.busy", busy, 0);
    check("rst.distance", distance, 0);
    check("rst.dist_valid", dist_valid, 0);
    check("rst.timeout", timeout, 0);
    rst = 1'b0; start = 1'b0;
    repeat (10) tick();
    check("post_rst.idle", busy, 0);
    check("post_rst.trig", trig, 0);

    foreach (vecs[i])
      run(vecs[i].name, vecs[i].pre_us, vecs[i].delay_us, vecs[i].width_us,
          vecs[i].exp_valid, vecs[i].exp_t, vecs[i].exp_dist);

    prev = vecs[5].exp_dist;
    for (int k = 0; k < 4; k++) begin
      d_us = $urandom_range(1, 30);
      w_us = $urandom_range(1, 200);
      model(d_us, w_us, prev, ev, et, ed);
      run($sformatf("rand%0d", k), 0, d_us, w_us, ev, et, ed);
      prev = ed;
    end

    // Reset in the middle of a measurement.
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (trig === 1'b1 && n < 1000) begin tick(); n++; end
    check("rstm.trig_fell", trig, 0);
    echo = 1'b1;
    repeat (60) tick();
    check("rstm.busy_before", busy, 1);
    n = dv_cnt + to_cnt;
    rst = 1'b1;
    tick();
    check("rstm.trig", trig, 0);
    check("rstm.busy", busy, 0);
    check("rstm.distance", distance, 0);
    check("rstm.strobes", {30'd0, dist_valid, timeout}, 0);
    rst = 1'b0; echo = 1'b0;
    repeat (30) tick();
    check("rstm.no_strobe_after", dv_cnt + to_cnt, n);
    check("rstm.idle", busy, 0);

    check("strobe_overlap", both_cnt, 0);
    check("strobe_width", long_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
